// File: rtl/data_cache_responder.sv
// data_cache_responder: direct-mapped, write-back, write-allocate data cache
// serving CPU word reads/byte-masked writes, filling/evicting 256-bit lines.
module data_cache_responder #(
    parameter int NUM_SETS   = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    input  logic [3:0]            mem_byte_enable,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [31:0]           mem_wdata,
    output logic [31:0]           mem_rdata,
    output logic                  mem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [255:0]          pmem_wdata,
    input  logic [255:0]          pmem_rdata,
    input  logic                  pmem_resp
);
    localparam int IDX = $clog2(NUM_SETS);
    localparam int TAG = ADDR_WIDTH - IDX - 5;

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t              r_state, w_next;
    logic [NUM_SETS-1:0] r_valid, r_dirty;
    logic [TAG-1:0]      r_tag [NUM_SETS];
    logic [255:0]        r_line [NUM_SETS];
    logic [IDX-1:0]      r_idx;
    logic [TAG-1:0]      r_req_tag;

    logic [IDX-1:0] w_idx;
    logic [TAG-1:0] w_tag;
    logic [7:0]     w_off;
    logic           w_req, w_hit, w_miss, w_wr_hit, w_fill, w_wb_done, w_unused;
    logic [31:0]    w_cur_word, w_merged;

    assign w_idx      = mem_address[IDX+4:5];
    assign w_tag      = mem_address[ADDR_WIDTH-1:IDX+5];
    assign w_off      = {mem_address[4:2], 5'b0};
    assign w_unused   = &{1'b0, mem_address[1:0]};
    assign w_req      = mem_read | mem_write;
    assign w_hit      = w_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_miss     = (r_state == COMPARE) & w_req & ~w_hit;
    assign w_wr_hit   = (r_state == COMPARE) & w_hit & mem_write;
    assign w_fill     = (r_state == ALLOCATE) & pmem_resp;
    assign w_wb_done  = (r_state == WRITEBACK) & pmem_resp;
    assign w_cur_word = r_line[w_idx][w_off +: 32];

    always_comb begin
        w_merged = w_cur_word;
        for (int i = 0; i < 4; i++)
            w_merged[8*i +: 8] = mem_byte_enable[i] ? mem_wdata[8*i +: 8] : w_cur_word[8*i +: 8];
    end

    // Miss handling uses the captured index/tag so a dropped request still completes cleanly
    always_comb begin
        w_next       = r_state;
        mem_resp     = 1'b0;
        mem_rdata    = '0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = '0;
        pmem_wdata   = '0;
        case (r_state)
            COMPARE: begin
                mem_resp  = w_hit;
                mem_rdata = (w_hit & ~mem_write) ? w_cur_word : '0;
                if (w_miss)
                    w_next = (r_valid[w_idx] & r_dirty[w_idx]) ? WRITEBACK : ALLOCATE;
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {r_tag[r_idx], r_idx, 5'b0};
                pmem_wdata   = r_line[r_idx];
                w_next       = pmem_resp ? ALLOCATE : WRITEBACK;
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {r_req_tag, r_idx, 5'b0};
                w_next       = pmem_resp ? COMPARE : ALLOCATE;
            end
            default: w_next = COMPARE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COMPARE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_next;
            if (w_wr_hit)
                r_dirty[w_idx] <= 1'b1;
            if (w_wb_done)
                r_dirty[r_idx] <= 1'b0;
            if (w_fill) begin
                r_valid[r_idx] <= 1'b1;
                r_dirty[r_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_miss) begin
            r_idx     <= w_idx;
            r_req_tag <= w_tag;
        end
        if (w_wr_hit)
            r_line[w_idx][w_off +: 32] <= w_merged;
        if (w_fill) begin
            r_line[r_idx] <= pmem_rdata;
            r_tag[r_idx]  <= r_req_tag;
        end
    end
endmodule

// File: tb/tb_data_cache_responder.sv
// tb_data_cache_responder: directed and random checks of data_cache_responder
// against a latency-modelled backing memory and a flat word reference.
module tb_data_cache_responder;
    localparam int LAT = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         mem_read = 1'b0, mem_write = 1'b0;
    logic [3:0]   mem_byte_enable = '0;
    logic [31:0]  mem_address = '0, mem_wdata = '0, mem_rdata;
    logic         mem_resp;
    logic         pmem_read, pmem_write, pmem_resp = 1'b0;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata, pmem_rdata = '0;

    int checks = 0, errors = 0;
    int cnt = 0;
    logic hold = 1'b0, both = 1'b0;
    logic [255:0] bmem [logic [31:0]];
    logic [31:0]  refm [logic [31:0]];
    logic [32:0]  evq [$];
    logic [255:0] last_wb;

    data_cache_responder dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_resp(mem_resp), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [255:0] line_of(input logic [31:0] a);
        logic [255:0] l;
        if (bmem.exists(a)) return bmem[a];
        for (int w = 0; w < 8; w++) l[32*w +: 32] = init_word(a | (w << 2));
        return l;
    endfunction

    // Backing memory: responds LAT cycles into a request, pulse lasts one cycle
    always @(negedge clk) begin
        if (pmem_read && pmem_write) both = 1'b1;
        if (pmem_resp || !(pmem_read || pmem_write)) begin
            pmem_resp = 1'b0;
            cnt = 0;
        end else if (!hold) begin
            cnt++;
            if (cnt >= LAT) begin
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    bmem[pmem_address] = pmem_wdata;
                    last_wb = pmem_wdata;
                end else
                    pmem_rdata = line_of(pmem_address);
                evq.push_back({pmem_write, pmem_address});
            end
        end
    end

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at a negedge with the request dropped
    task automatic req(input logic rd, input logic wr, input logic [3:0] be, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rdata, output int n);
        mem_read = rd; mem_write = wr; mem_byte_enable = be; mem_address = a; mem_wdata = wd;
        n = 0;
        #1;
        while (!mem_resp && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!mem_resp) check("resp_timeout", mem_resp, 1);
        rdata = mem_rdata;
        @(posedge clk);
        @(negedge clk);
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd, a, wd, cur;
        logic [3:0]  be;
        logic [255:0] l;
        int n;
        l = line_of(32'h1000);
        l[63:32] = 32'hDEAD_BEEF;
        bmem[32'h1000] = l;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mem_resp", mem_resp, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_pmem_read", pmem_read, 0);
        check("rst_pmem_write", pmem_write, 0);
        check("rst_pmem_address", pmem_address, 0);
        check("rst_pmem_wdata", pmem_wdata, 0);
        @(negedge clk);

        // Clean cold miss, then hit
        req(1, 0, 4'h0, 32'h1004, 0, rd, n);
        check("t1_rdata", rd, 32'hDEAD_BEEF);
        check("t1_lat", n, LAT + 1);
        check("t1_evn", evq.size(), 1);
        check("t1_ev0", evq[0], {1'b0, 32'h1000});
        req(1, 0, 4'hF, 32'h1004, 0, rd, n);
        check("t1_hit_lat", n, 0);
        check("t1_hit_rdata", rd, 32'hDEAD_BEEF);
        check("t1_hit_nopmem", evq.size(), 1);

        // Single-lane write hit
        req(0, 1, 4'b0100, 32'h1004, 32'h00AB_0000, rd, n);
        check("t2_wr_lat", n, 0);
        req(1, 0, 4'h0, 32'h1004, 0, rd, n);
        check("t2_rdata", rd, 32'hDEAB_BEEF);

        // Dirty conflict miss: writeback then fill
        evq.delete();
        req(1, 0, 4'h0, 32'h2004, 0, rd, n);
        check("t3_lat", n, 2 * LAT + 2);
        check("t3_evn", evq.size(), 2);
        check("t3_ev0", evq[0], {1'b1, 32'h1000});
        check("t3_ev1", evq[1], {1'b0, 32'h2000});
        check("t3_wb_word1", last_wb[63:32], 32'hDEAB_BEEF);
        check("t3_wb_word0", last_wb[31:0], 32'h5A5A_4A5A);
        check("t3_rdata", rd, 32'h5A5A_7A5E);

        // Clean conflict miss: fill only
        evq.delete();
        req(1, 0, 4'h0, 32'h4008, 0, rd, n);
        check("t4_lat", n, LAT + 1);
        check("t4_evn", evq.size(), 1);
        check("t4_ev0", evq[0], {1'b0, 32'h4000});
        check("t4_rdata", rd, 32'h5A5A_1A52);

        // Reset during a stalled allocate clears valid
        req(1, 0, 4'h0, 32'h1004, 0, rd, n);
        check("t5_refill_rdata", rd, 32'hDEAB_BEEF);
        hold = 1'b1;
        mem_read = 1'b1; mem_address = 32'h0000_0024;
        repeat (2) @(negedge clk);
        #1;
        check("t5_alloc_pmem_read", pmem_read, 1);
        check("t5_alloc_addr", pmem_address, 32'h20);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("t5_rst_pmem_read", pmem_read, 0);
        check("t5_rst_pmem_write", pmem_write, 0);
        check("t5_rst_mem_resp", mem_resp, 0);
        @(negedge clk);
        hold = 1'b0;
        req(1, 0, 4'h0, 32'h1004, 0, rd, n);
        check("t5_miss_lat", n, LAT + 1);

        // Empty byte mask still marks the line dirty without changing data
        req(0, 1, 4'h0, 32'h1004, 32'hFFFF_FFFF, rd, n);
        check("t6_wr_lat", n, 0);
        evq.delete();
        req(1, 0, 4'h0, 32'h2004, 0, rd, n);
        check("t6_dirty_lat", n, 2 * LAT + 2);
        check("t6_ev0", evq[0], {1'b1, 32'h1000});
        req(1, 0, 4'h0, 32'h1004, 0, rd, n);
        check("t6_unchanged", rd, 32'hDEAB_BEEF);

        // Random mix against a flat word model
        for (int k = 0; k < 2000; k++) begin
            a = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
            cur = refm.exists(a) ? refm[a] : init_word(a);
            if ($urandom_range(0, 1)) begin
                be = 4'($urandom);
                wd = $urandom;
                for (int i = 0; i < 4; i++) if (be[i]) cur[8*i +: 8] = wd[8*i +: 8];
                refm[a] = cur;
                req(0, 1, be, a, wd, rd, n);
            end else begin
                req(1, 0, 4'($urandom), a, 0, rd, n);
                check("rand_rdata", rd, cur);
            end
        end
        check("pmem_exclusive", both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
